// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // Fault/redirect causes, shared with decode and hazard logic
  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_REDIRECT   = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;
  localparam logic [1:0] CAUSE_RANGE      = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-pc selection with redirect, stall and fault detection
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic         i_state_fault,
  input  logic [31:0]  i_pc,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  input  logic         i_stall,
  output logic [31:0]  o_next_pc,
  output logic         o_flush,
  output logic         o_fault_trig
);

  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  always_comb begin
    o_next_pc    = i_pc;
    o_flush      = 1'b0;
    o_fault_trig = 1'b0;
    if (!i_state_fault) begin
      // Redirect outranks stall so a taken branch is never lost behind a hazard
      if (i_redirect) begin
        o_flush = 1'b1;
        if (i_redirect_pc[1:0] != 2'b00) begin
          o_fault_trig = 1'b1;
        end else begin
          o_next_pc = i_redirect_pc;
        end
      end else if (!i_stall) begin
        if (i_pc[31:2] >= DEPTH_W) begin
          o_fault_trig = 1'b1;
          o_flush      = 1'b1;
        end else begin
          o_next_pc = i_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - pc register, fetch state machine and IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_instr;
  logic         r_if_valid;
  logic [31:0]  w_next_pc;
  logic         w_flush;
  logic         w_fault_trig;

  pc_next_sel #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_pc_next_sel (
    .i_state_fault(r_state == ST_FAULT),
    .i_pc         (r_pc),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_stall      (stall),
    .o_next_pc    (w_next_pc),
    .o_flush      (w_flush),
    .o_fault_trig (w_fault_trig)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_fault_trig) w_state_next = ST_FAULT;
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_FAULT;
    endcase
  end

  // FAULT entry already flushed IF/ID, so the FAULT state simply freezes everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_if_pc    <= 32'h0;
      r_if_instr <= NOP;
      r_if_valid <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_pc <= w_next_pc;
      if (w_flush) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP;
      end else if (!stall) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_instr;
        r_if_valid <= 1'b1;
      end
    end
  end

  assign imem_addr = {2'b00, r_pc[31:2]};
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign if_valid  = r_if_valid;
  assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fault;

  logic [31:0] mem [0:63];
  int n_pass;
  int n_total;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .fault      (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imem_instr = (imem_addr < 32'd64) ? mem[imem_addr[5:0]] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    reset = 1'b1;
    #12;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== NOP_W) $display("FAIL rst_instr got %h exp %h", if_instr, NOP_W); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", if_pc); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", fault); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [0:3];
    exp_instr[0] = 32'h00A2_00B3;
    exp_instr[1] = 32'h4031_00B3;
    exp_instr[2] = 32'h0062_E0B3;
    exp_instr[3] = 32'h0000_0013;
    do_reset();
    n_total++; if (imem_addr !== 32'd0) $display("FAIL seq_addr0 got %h exp 0", imem_addr); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++; if (if_pc !== 32'(4 * k)) $display("FAIL seq_pc%0d got %h exp %h", k, if_pc, 32'(4 * k)); else n_pass++;
      n_total++; if (if_instr !== exp_instr[k]) $display("FAIL seq_instr%0d got %h exp %h", k, if_instr, exp_instr[k]); else n_pass++;
      n_total++; if (if_valid !== 1'b1) $display("FAIL seq_valid%0d got %b exp 1", k, if_valid); else n_pass++;
      n_total++; if (imem_addr !== 32'(k + 1)) $display("FAIL seq_addr%0d got %h exp %h", k, imem_addr, 32'(k + 1)); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      redirect = 1'b1; redirect_pc = 32'h4; stall = (s == 1);
      step();
      redirect = 1'b0; stall = 1'b0;
      n_total++; if (if_valid !== 1'b0) $display("FAIL redir%0d_bubble_valid got %b exp 0", s, if_valid); else n_pass++;
      n_total++; if (if_instr !== NOP_W) $display("FAIL redir%0d_bubble_instr got %h exp %h", s, if_instr, NOP_W); else n_pass++;
      n_total++; if (imem_addr !== 32'd1) $display("FAIL redir%0d_addr got %h exp 1", s, imem_addr); else n_pass++;
      step();
      n_total++; if (if_pc !== 32'h4) $display("FAIL redir%0d_pc got %h exp 4", s, if_pc); else n_pass++;
      n_total++; if (if_instr !== 32'h4031_00B3) $display("FAIL redir%0d_instr got %h exp 403100b3", s, if_instr); else n_pass++;
      n_total++; if (if_valid !== 1'b1) $display("FAIL redir%0d_valid got %b exp 1", s, if_valid); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++; if (if_pc !== 32'h4) $display("FAIL stall%0d_pc got %h exp 4", c, if_pc); else n_pass++;
      n_total++; if (if_instr !== 32'h4031_00B3) $display("FAIL stall%0d_instr got %h exp 403100b3", c, if_instr); else n_pass++;
      n_total++; if (if_valid !== 1'b1) $display("FAIL stall%0d_valid got %b exp 1", c, if_valid); else n_pass++;
      n_total++; if (imem_addr !== 32'd2) $display("FAIL stall%0d_addr got %h exp 2", c, imem_addr); else n_pass++;
    end
    stall = 1'b0;
    step();
    n_total++; if (if_pc !== 32'h8) $display("FAIL stall_rel_pc got %h exp 8", if_pc); else n_pass++;
    n_total++; if (if_instr !== 32'h0062_E0B3) $display("FAIL stall_rel_instr got %h exp 0062e0b3", if_instr); else n_pass++;
    step();
    n_total++; if (if_pc !== 32'hC) $display("FAIL stall_rel2_pc got %h exp c", if_pc); else n_pass++;
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
    n_total++; if (fault !== 1'b1) $display("FAIL mis_fault got %b exp 1", fault); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL mis_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== NOP_W) $display("FAIL mis_instr got %h exp %h", if_instr, NOP_W); else n_pass++;
    n_total++; if (imem_addr !== 32'd1) $display("FAIL mis_addr got %h exp 1", imem_addr); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    step();
    redirect = 1'b0;
    n_total++; if (imem_addr !== 32'd1) $display("FAIL mis_frozen_addr got %h exp 1", imem_addr); else n_pass++;
    n_total++; if (fault !== 1'b1) $display("FAIL mis_sticky got %b exp 1", fault); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL mis_frozen_valid got %b exp 0", if_valid); else n_pass++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    for (int k = 0; k < 32; k++) step();
    n_total++; if (if_pc !== 32'h7C) $display("FAIL oor_last_pc got %h exp 7c", if_pc); else n_pass++;
    n_total++; if (if_instr !== 32'h01F0_0013) $display("FAIL oor_last_instr got %h exp 01f00013", if_instr); else n_pass++;
    n_total++; if (if_valid !== 1'b1) $display("FAIL oor_last_valid got %b exp 1", if_valid); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL oor_early_fault got %b exp 0", fault); else n_pass++;
    n_total++; if (imem_addr !== 32'd32) $display("FAIL oor_addr got %h exp 20", imem_addr); else n_pass++;
    step();
    n_total++; if (fault !== 1'b1) $display("FAIL oor_fault got %b exp 1", fault); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL oor_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== NOP_W) $display("FAIL oor_instr got %h exp %h", if_instr, NOP_W); else n_pass++;
    step();
    n_total++; if (imem_addr !== 32'd32) $display("FAIL oor_frozen_addr got %h exp 20", imem_addr); else n_pass++;
    n_total++; if (fault !== 1'b1) $display("FAIL oor_sticky got %b exp 1", fault); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    n_total++; if (fault !== 1'b1) $display("FAIL ar_pre_fault got %b exp 1", fault); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h10;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (imem_addr !== 32'd0) $display("FAIL ar_addr got %h exp 0", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL ar_fault got %b exp 0", fault); else n_pass++;
    n_total++; if (if_instr !== NOP_W) $display("FAIL ar_instr got %h exp %h", if_instr, NOP_W); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL ar_pc got %h exp 0", if_pc); else n_pass++;
    redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    step();
    n_total++; if (if_pc !== 32'h0) $display("FAIL ar_restart_pc got %h exp 0", if_pc); else n_pass++;
    n_total++; if (if_instr !== 32'h00A2_00B3) $display("FAIL ar_restart_instr got %h exp 00a200b3", if_instr); else n_pass++;
    n_total++; if (if_valid !== 1'b1) $display("FAIL ar_restart_valid got %b exp 1", if_valid); else n_pass++;
    step();
    n_total++; if (if_pc !== 32'h4) $display("FAIL ar_restart_pc2 got %h exp 4", if_pc); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    mem[0] = 32'h00A2_00B3;
    mem[1] = 32'h4031_00B3;
    mem[2] = 32'h0062_E0B3;
    mem[3] = 32'h0000_0013;
    for (int i = 4; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_misaligned();
    test_out_of_range();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
